// File: rtl/mult2x2_seq_ctrl_if.sv
// Operand/product handshake bundle for mult2x2_seq_ctrl: valid/ready in on the
// requester side, valid/ready out on the consumer side, plus a busy indicator.
interface mult2x2_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mult2x2_seq_ctrl.sv
// WIDTH x WIDTH unsigned multiplier built from one 2x2 array core, iterating
// over all digit pairs (j inner, i outer) and accumulating shifted partials.
module mult2x2_core (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  logic pp10;
  logic pp01;
  logic pp11;
  logic c1;

  assign pp10 = x[1] & y[0];
  assign pp01 = x[0] & y[1];
  assign pp11 = x[1] & y[1];
  assign c1   = pp10 & pp01;

  assign p[0] = x[0] & y[0];
  assign p[1] = pp10 ^ pp01;
  assign p[2] = pp11 ^ c1;
  assign p[3] = pp11 & c1;
endmodule

module mult2x2_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mult2x2_seq_ctrl_if.slave   bus
);
  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   i_idx;
  logic [IDX_W-1:0]   j_idx;
  logic [1:0]         a_dig;
  logic [1:0]         b_dig;
  logic [3:0]         pp;
  logic [IDX_W:0]     dig_sum;
  logic [ACC_W-1:0]   pp_term;
  logic               accept;
  logic               last_j;
  logic               last_step;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_j    = (j_idx == LAST_IDX);
  assign last_step = last_j && (i_idx == LAST_IDX);

  // Digit selection and weighting of the partial product by 4^(i+j)
  assign a_dig   = 2'(a_reg >> {i_idx, 1'b0});
  assign b_dig   = 2'(b_reg >> {j_idx, 1'b0});
  assign dig_sum = {1'b0, i_idx} + {1'b0, j_idx};
  assign pp_term = ACC_W'(pp) << {dig_sum, 1'b0};

  mult2x2_core u_core (
    .x (a_dig),
    .y (b_dig),
    .p (pp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_step)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Operand latch, digit indices and accumulator; all held outside IDLE-accept and RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
    end else if (accept) begin
      a_reg <= bus.a;
      b_reg <= bus.b;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
    end else if (state == RUN) begin
      acc <= acc + pp_term;
      if (last_j) begin
        j_idx <= '0;
        i_idx <= (i_idx == LAST_IDX) ? '0 : i_idx + 1'b1;
      end else begin
        j_idx <= j_idx + 1'b1;
      end
    end
  end

  assign bus.product = acc;
endmodule
